param_signal_monitor: RTL and testbench
=======================================

PARAM_SIGNAL_MONITOR -- requirements
Module: param_signal_monitor

Interface
REQ-001 Parameter W, default 8: data width of signal_a, signal_b, threshold and control_out.
REQ-002 Parameter CNT_W, default 4: width of persist and the internal run counter.
REQ-003 Parameter STEP, default 5: test-ramp increment per sample, taken modulo 2^W.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 en  in  1  sample strobe; inputs are consumed only on cycles where en=1.
REQ-007 signal_a, signal_b  in  W  unsigned operands.
REQ-008 mode_select  in  2  mode: 00 add, 01 abs-diff, 10 test ramp, 11 average.
REQ-009 threshold  in  W  unsigned alarm threshold.
REQ-010 persist  in  CNT_W  consecutive excursions required to raise alarm; 0 is treated as 1.
REQ-011 alarm_clr  in  1  clears a latched alarm.
REQ-012 control_out  out  W  registered result.
REQ-013 status_leds  out  3  registered status, updated together with control_out.
REQ-014 out_valid  out  1  one-cycle pulse marking a new control_out.
REQ-015 overflow  out  1  registered; high while control_out holds a saturated add result.
REQ-016 alarm  out  1  registered; high in ALARM state.

Function
REQ-017 Latency: an en=1 sample at edge N SHALL appear on control_out/status_leds/overflow after edge N, with out_valid=1 for exactly that cycle.
REQ-018 en=0: control_out, status_leds, overflow hold; out_valid=0; test counter and alarm FSM hold, except for alarm_clr.
REQ-019 All arithmetic is computed at W+1 bits; no intermediate truncation.
REQ-020 Mode 00: sum=a+b; if sum>2^W-1, control_out=all ones and overflow=1; else control_out=sum and overflow=0; status_leds=001.
REQ-021 Mode 01: control_out=|a-b|; status_leds=100 if a>b, 010 if a<b, 001 if a==b (control_out=0); overflow=0.
REQ-022 Mode 10: control_out=ramp counter value; then the counter advances by STEP modulo 2^W (wraps, no saturation); status_leds=111; overflow=0.
REQ-023 Ramp counter SHALL clear to 0 on any clock edge where mode_select!=10, regardless of en.
REQ-024 Mode 11: control_out=(a+b)>>1 computed on W+1 bits, so a=b=2^W-1 yields 2^W-1; status_leds=111; overflow=0.
REQ-025 Excursion: an en=1 sample in modes 00/01/11 whose control_out result exceeds threshold (strictly greater). Mode 10 samples leave the FSM and run counter unchanged.
REQ-026 Alarm FSM states: IDLE, ARMING, ALARM; run counter saturates at 2^CNT_W-1.
REQ-027 IDLE: an excursion sets run=1; go to ALARM if effective persist==1, else ARMING.
REQ-028 ARMING: an excursion increments run and goes to ALARM when run reaches persist; a non-excursion sample returns to IDLE with run=0.
REQ-029 ALARM: hold regardless of samples until alarm_clr.
REQ-030 alarm_clr=1 on any edge SHALL force IDLE with run=0 and takes priority over a simultaneous excursion; that sample does not count.
REQ-031 A persist change mid-run is compared against the current run on the next excursion only.

Reset
REQ-032 reset=1 SHALL immediately force control_out=0, status_leds=000, out_valid=0, overflow=0, alarm=0, ramp counter=0, run=0, and FSM=IDLE.
REQ-033 Reset asserted mid-ARMING or mid-ALARM SHALL discard all progress; the first post-reset sample is evaluated from IDLE.

Verification (W=8, CNT_W=4, STEP=5)
REQ-034 Mode 00, a=200, b=100, en=1 -> next cycle control_out=255, overflow=1, status_leds=001, out_valid=1; then a=10, b=20 -> control_out=30, overflow=0.
REQ-035 Mode 01, a=3, b=9 -> control_out=6, status_leds=010; a=b=7 -> control_out=0, status_leds=001.
REQ-036 Mode 10, en=1 for 53 samples -> control_out 0,5,10,...,255, then 4 (wrap); switch to mode 00 for one edge and back to mode 10 -> first ramp output 0.
REQ-037 Mode 11, a=b=255 -> control_out=255; a=1, b=2 -> control_out=1.
REQ-038 threshold=50, persist=3, mode 00: sample results 60,60,40,60,60,60 -> alarm rises after the 6th sample only and stays high through later results of 0; alarm_clr together with an excursion -> alarm=0, FSM IDLE, run=0.
REQ-039 persist=0, a single excursion -> alarm=1 after one sample; assert reset mid-ALARM -> all outputs 0 at once.

Source files
------------

// File: rtl/param_signal_monitor.sv
// param_signal_monitor: arithmetic/ramp result generator with a persistence-filtered alarm
module param_signal_monitor #(
    parameter int W     = 8,
    parameter int CNT_W = 4,
    parameter int STEP  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [W-1:0]     signal_a,
    input  logic [W-1:0]     signal_b,
    input  logic [1:0]       mode_select,
    input  logic [W-1:0]     threshold,
    input  logic [CNT_W-1:0] persist,
    input  logic             alarm_clr,
    output logic [W-1:0]     control_out,
    output logic [2:0]       status_leds,
    output logic             out_valid,
    output logic             overflow,
    output logic             alarm
);
    typedef enum logic [1:0] {IDLE, ARMING, ALARMED} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0] run, run_n, run_inc, eff_persist;
    logic [W-1:0] ramp, res, diff;
    logic [W:0] sum;
    logic [2:0] leds;
    logic ovf, scored, exc;
    // Per-mode result, status and saturation flag, all from one W+1 bit sum
    always_comb begin
        sum = {1'b0, signal_a} + {1'b0, signal_b};
        diff = signal_a > signal_b ? signal_a - signal_b : signal_b - signal_a;
        res = mode_select == 2'b00 ? (sum[W] ? '1 : sum[W-1:0]) :
              mode_select == 2'b01 ? diff :
              mode_select == 2'b10 ? ramp : sum[W:1];
        leds = mode_select == 2'b01 ? (signal_a > signal_b ? 3'b100 : signal_a < signal_b ? 3'b010 : 3'b001) :
               mode_select == 2'b00 ? 3'b001 : 3'b111;
        ovf = mode_select == 2'b00 && sum[W];
        scored = en && mode_select != 2'b10;
        exc = scored && res > threshold;
        eff_persist = persist == '0 ? CNT_W'(1) : persist;
        run_inc = &run ? run : run + CNT_W'(1);
    end
    // Result registers; hold while no sample strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            control_out <= '0;
            status_leds <= '0;
            overflow <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= en;
            if (en) begin
                control_out <= res;
                status_leds <= leds;
                overflow <= ovf;
            end
        end
    end
    // Test ramp: restarts whenever another mode is selected, advances on sampled ramp cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ramp <= '0;
        else if (mode_select != 2'b10) ramp <= '0;
        else if (en) ramp <= ramp + W'(STEP);
    end
    // Alarm state and run counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            run <= '0;
        end else begin
            state <= state_n;
            run <= run_n;
        end
    end
    // Alarm next state: clear wins, then only scored samples move the FSM
    always_comb begin
        state_n = state;
        run_n = run;
        if (alarm_clr) begin
            state_n = IDLE;
            run_n = '0;
        end else if (scored) begin
            case (state)
                IDLE: if (exc) begin
                    run_n = CNT_W'(1);
                    state_n = eff_persist == CNT_W'(1) ? ALARMED : ARMING;
                end
                ARMING: if (exc) begin
                    run_n = run_inc;
                    state_n = run_inc >= eff_persist ? ALARMED : ARMING;
                end else begin
                    run_n = '0;
                    state_n = IDLE;
                end
                default: ;
            endcase
        end
    end
    // Alarm output decoded from the state register
    always_comb alarm = state == ALARMED;
endmodule

// File: tb/tb_param_signal_monitor.sv
// tb_param_signal_monitor: random and directed checks against a behavioural model
module tb_param_signal_monitor;
    localparam int W = 8, CNT_W = 4, STEP = 5, MAXV = (1 << W) - 1, MAXR = (1 << CNT_W) - 1;
    logic clk = 0, reset = 1, en = 0, alarm_clr = 0;
    logic [W-1:0] signal_a = 0, signal_b = 0, threshold = 0;
    logic [1:0] mode_select = 0;
    logic [CNT_W-1:0] persist = 0;
    logic [W-1:0] control_out;
    logic [2:0] status_leds;
    logic out_valid, overflow, alarm;
    int errs = 0, checks = 0;
    int m_out = 0, m_leds = 0, m_ovf = 0, m_vld = 0, m_ramp = 0, m_run = 0, m_alarm = 0;

    param_signal_monitor #(.W(W), .CNT_W(CNT_W), .STEP(STEP)) dut (
        .clk(clk), .reset(reset), .en(en), .signal_a(signal_a), .signal_b(signal_b),
        .mode_select(mode_select), .threshold(threshold), .persist(persist), .alarm_clr(alarm_clr),
        .control_out(control_out), .status_leds(status_leds), .out_valid(out_valid),
        .overflow(overflow), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".out"}, int'(control_out), m_out);
        chk({tag, ".leds"}, int'(status_leds), m_leds);
        chk({tag, ".ovf"}, int'(overflow), m_ovf);
        chk({tag, ".vld"}, int'(out_valid), m_vld);
        chk({tag, ".alarm"}, int'(alarm), m_alarm);
    endtask

    task automatic model_reset();
        m_out = 0; m_leds = 0; m_ovf = 0; m_vld = 0; m_ramp = 0; m_run = 0; m_alarm = 0;
    endtask

    // one clock edge with the given inputs, then model update and comparison
    task automatic apply(input string tag, input int e, input int a, input int b, input int md,
                         input int th, input int pr, input int c);
        int r, l, o, p;
        en = e[0]; signal_a = a[W-1:0]; signal_b = b[W-1:0]; mode_select = md[1:0];
        threshold = th[W-1:0]; persist = pr[CNT_W-1:0]; alarm_clr = c[0];
        @(posedge clk);
        o = 0;
        case (md)
            0: begin r = a + b; o = r > MAXV ? 1 : 0; r = o ? MAXV : r; l = 1; end
            1: begin r = a > b ? a - b : b - a; l = a > b ? 4 : (a < b ? 2 : 1); end
            2: begin r = m_ramp; l = 7; end
            default: begin r = (a + b) / 2; l = 7; end
        endcase
        if (md != 2) m_ramp = 0;
        else if (e != 0) m_ramp = (m_ramp + STEP) % (MAXV + 1);
        p = pr == 0 ? 1 : pr;
        if (c != 0) begin
            m_alarm = 0; m_run = 0;
        end else if (e != 0 && md != 2 && m_alarm == 0) begin
            if (r > th) begin
                m_run = m_run < MAXR ? m_run + 1 : MAXR;
                if (m_run >= p) m_alarm = 1;
            end else m_run = 0;
        end
        m_vld = e;
        if (e != 0) begin m_out = r; m_leds = l; m_ovf = o; end
        #1;
        chk_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #3 reset = 1;
        #1;
        model_reset();
        chk_all(tag);
        @(posedge clk);
        #1 reset = 0;
    endtask

    initial begin
        int md, e;
        #2;
        model_reset();
        chk_all("reset");
        @(posedge clk);
        #1 reset = 0;
        // saturating add and plain add
        apply("add_sat", 1, 200, 100, 0, 255, 0, 0);
        apply("add", 1, 10, 20, 0, 255, 0, 0);
        apply("hold", 0, 99, 99, 1, 255, 0, 0);
        // absolute difference
        apply("diff_lt", 1, 3, 9, 1, 255, 0, 0);
        apply("diff_eq", 1, 7, 7, 1, 255, 0, 0);
        apply("diff_gt", 1, 9, 3, 1, 255, 0, 0);
        // ramp through wrap, restart after a one-edge mode change
        for (int i = 0; i < 53; i++) apply("ramp", 1, 0, 0, 2, 255, 0, 0);
        chk("ramp_wrap", int'(control_out), 4);
        apply("ramp_hold", 0, 0, 0, 2, 255, 0, 0);
        apply("ramp_brk", 0, 0, 0, 0, 255, 0, 0);
        apply("ramp_rst", 1, 0, 0, 2, 255, 0, 0);
        chk("ramp_first", int'(control_out), 0);
        // average
        apply("avg_max", 1, 255, 255, 3, 255, 0, 0);
        apply("avg", 1, 1, 2, 3, 255, 0, 0);
        // persistence: 60,60,40,60,60,60 with persist 3
        apply("p1", 1, 60, 0, 0, 50, 3, 0);
        apply("p2", 1, 60, 0, 0, 50, 3, 0);
        apply("p3", 1, 40, 0, 0, 50, 3, 0);
        apply("p4", 1, 60, 0, 0, 50, 3, 0);
        apply("p5", 1, 60, 0, 0, 50, 3, 0);
        chk("no_alarm_yet", int'(alarm), 0);
        apply("p6", 1, 60, 0, 0, 50, 3, 0);
        chk("alarm_up", int'(alarm), 1);
        apply("p7", 1, 0, 0, 0, 50, 3, 0);
        apply("p8", 1, 0, 0, 0, 50, 3, 0);
        apply("clr_exc", 1, 60, 0, 0, 50, 3, 1);
        chk("alarm_clr", int'(alarm), 0);
        apply("after_clr1", 1, 60, 0, 0, 50, 3, 0);
        apply("after_clr2", 1, 60, 0, 0, 50, 3, 0);
        apply("after_clr3", 1, 60, 0, 0, 50, 3, 0);
        // persist 0 acts as 1, then reset mid-alarm
        apply("clr", 0, 0, 0, 0, 50, 0, 1);
        apply("p0", 1, 70, 0, 0, 50, 0, 0);
        chk("p0_alarm", int'(alarm), 1);
        do_reset("rst_alarm");
        apply("post_rst", 1, 70, 0, 0, 50, 2, 0);
        chk("post_rst_alarm", int'(alarm), 0);
        // randomized traffic
        md = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) md = int'($urandom_range(0, 3));
            e = $urandom_range(0, 3) != 0 ? 1 : 0;
            if ($urandom_range(0, 149) == 0) do_reset("rnd_rst");
            apply("rnd", e, int'($urandom_range(0, MAXV)), int'($urandom_range(0, MAXV)), md,
                  int'($urandom_range(0, MAXV)), int'($urandom_range(0, 4)),
                  $urandom_range(0, 19) == 0 ? 1 : 0);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
